lfsr_stream: RTL and testbench
==============================

# lfsr_stream

- Parametrised successor of the single-bit LFSR counter.
- Advances a WIDTH-bit Galois LFSR by STEP sub-steps per accepted beat.
- Emits the STEP feedback bits per beat on a valid/ready stream, with a synchronous seed/tap load command and an idle/run state machine.
- Sits between a configuration register block and pseudo-random consumers (test-pattern generators, dither, scramblers); an optional period monitor reports sequence wrap.

## Interface
- WIDTH, 8, LFSR state width; legal range 3..32.
- STEP, 1, sub-steps (output bits) per beat; legal range 1..WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- tap  in  WIDTH  tap mask; bit 0 ignored; all-zeros or all-ones replaced by 2 ('b...010).
- seed  in  WIDTH  initial state.
- load  in  1  capture seed and sanitized tap.
- en  in  1  run enable.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_data  out  STEP  feedback bits of this beat; bit i = sub-step i (bit 0 first).
- state  out  WIDTH  current LFSR state.
- wrap  out  1  (macro only) one-cycle pulse when the sequence returns to the loaded seed.
- period  out  WIDTH+1  (macro only) beats between the last two seed visits.

## Operation
- Sub-step on state s with captured tap t:
  - fb = s[WIDTH-1] ^ (s[WIDTH-2:0] == 0).
  - s'[0] = fb.
  - s'[b] = t[b] ? s[b-1]^fb : s[b-1] for b = 1..WIDTH-1.
- All-zero state is legal; it is not a lock-up.
- Beat: STEP chained sub-steps; out_data[i] = fb of sub-step i, computed combinationally from registered state.
- FSM:
  - IDLE: out_valid=0.
  - IDLE -> RUN when en=1.
  - RUN: out_valid=1.
  - RUN -> IDLE when en=0 and (out_ready=1 or the stall is resolved); valid never drops while a beat is unaccepted except on load or reset.
- Handshake: state advances one beat only on out_valid && out_ready; while stalled, state and out_data hold.
- load=1, any state: state<=seed, tap_q<=sanitized tap, FSM<=IDLE, out_valid drops next cycle. Load aborts a stalled beat (documented exception).
- load and handshake in the same cycle: load wins, no advance.
- Reset (rst=0 at a clock edge):
  - state<=seed, tap_q<=sanitized tap, FSM=IDLE, out_valid=0.
  - wrap=0, period=0, counter=0.
  - Identical mid-operation.

## Timing
- load/reset at edge t: state == seed after t; out_valid earliest at t+1 if en=1.
- IDLE->RUN: one cycle from en rising to out_valid.
- Throughput: one beat (STEP bits) per cycle with out_ready held high.
- out_data valid in the same cycle as out_valid; no added latency.
- Combinational depth grows linearly with STEP; STEP=WIDTH is timing-critical.

## Configuration
- LFSR_STREAM_PERIOD_EN defined:
  - Beat counter (WIDTH+1 bits, saturating) increments per accepted beat and clears on load/reset.
  - When the post-beat state equals the captured seed: wrap pulses 1 cycle, period<=count+1, counter<=0.
  - Seed compare occurs only at beat boundaries.
- Undefined: wrap and period ports, counter and seed_q register absent; the remaining behaviour is identical.

## Structure
- Package lfsr_pkg:
  - FSM state enum (IDLE, RUN).
  - Tap fallback constant (2).
  - Function sanitize_tap.
- Sub-module lfsr_step: combinational single sub-step (s, t -> s', fb), instantiated STEP times in a generate chain.

## Test plan
- WIDTH=8, STEP=1, tap=0x1D, seed=0x01, en=1, ready=1 -> states 0x01, 0x02, 0x04 … 0x80, 0x00, 0x1D; out_data 0,0,…,0,1 at 0x00.
- tap=0xFF and tap=0x00, seed=0x00, load then run -> first beat state 0x03 (fallback tap 0x02), out_data=1.
- ready toggled 1,0,0,1 in RUN -> out_valid stays 1, state and out_data frozen for the two stall cycles, advance on accept only.
- Mid-stall load with seed=0xA5 -> out_valid=0 next cycle, state=0xA5, no beat counted; en=0 during stall -> IDLE only after accept.
- STEP=4, tap=0x1D, seed=0x80 -> one beat yields state 0x74, out_data=4'b0010 (sub-states 0x00, 0x1D, 0x3A, 0x74).
- LFSR_STREAM_PERIOD_EN, WIDTH=4, tap=0x2, seed=0x1 -> wrap pulses after 16 accepted beats, period=16; rst=0 mid-count -> wrap=0, period=0.

Source files
------------

// File: rtl/lfsr_stream_pkg.sv
// rtl/lfsr_stream_pkg.sv - shared types, constants and tap sanitizer for lfsr_stream
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    localparam logic [31:0] TAP_FALLBACK = 32'd2;

    // Bit 0 never acts as a tap, so degenerate masks are judged on bits [width-1:1].
    function automatic logic [31:0] sanitize_tap(input logic [31:0] tap, input int unsigned width);
        logic [31:0] mask;
        logic [31:0] t;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        mask = mask & ~32'd1;
        t    = tap & mask;
        if (t == 32'd0 || t == mask) begin
            return TAP_FALLBACK;
        end
        return t;
    endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// rtl/lfsr_stream_if.sv - valid/ready beat stream carrying STEP feedback bits
interface lfsr_stream_if #(
    parameter int STEP = 1
);
    logic            out_valid;
    logic            out_ready;
    logic [STEP-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_stream_step.sv
// rtl/lfsr_stream_step.sv - one combinational Galois sub-step with zero-state escape
module lfsr_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_s,
    input  logic [WIDTH-1:1] i_t,
    output logic [WIDTH-1:0] o_s,
    output logic             o_fb
);
    logic w_fb;

    // The zero-detect term makes the all-zero state part of the cycle instead of a lock-up.
    assign w_fb = i_s[WIDTH-1] ^ (i_s[WIDTH-2:0] == '0);
    assign o_s  = {i_s[WIDTH-2:0], w_fb} ^ ({i_t, 1'b0} & {WIDTH{w_fb}});
    assign o_fb = w_fb;
endmodule

// File: rtl/lfsr_stream.sv
// rtl/lfsr_stream.sv - WIDTH-bit Galois LFSR streaming STEP bits per beat; LFSR_STREAM_PERIOD_EN adds the period monitor
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_tap,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_load,
    input  logic             i_en,
    lfsr_stream_if.master    o_out,
`ifdef LFSR_STREAM_PERIOD_EN
    output logic             o_wrap,
    output logic [WIDTH:0]   o_period,
`endif
    output logic [WIDTH-1:0] o_state
);
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:1] r_tap;
    fsm_t             r_fsm;
    logic             r_valid;

    logic [WIDTH-1:1] w_tap_san;
    logic [WIDTH-1:0] w_chain [0:STEP];
    logic [STEP-1:0]  w_fb;
    logic [WIDTH-1:0] w_next;
    logic             w_fire;

    assign w_tap_san = (WIDTH-1)'(sanitize_tap(32'(i_tap), WIDTH) >> 1);

    assign w_chain[0] = r_state;
    for (genvar g = 0; g < STEP; g++) begin : g_step
        lfsr_step #(.WIDTH(WIDTH)) u_step (
            .i_s  (w_chain[g]),
            .i_t  (r_tap),
            .o_s  (w_chain[g+1]),
            .o_fb (w_fb[g])
        );
    end
    assign w_next = w_chain[STEP];
    assign w_fire = r_valid & o_out.out_ready;

`ifdef LFSR_STREAM_PERIOD_EN
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH:0]   r_cnt;
    logic             r_wrap;
    logic [WIDTH:0]   r_period;
    logic [WIDTH:0]   w_cnt_inc;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign o_wrap    = r_wrap;
    assign o_period  = r_period;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_load) begin
            // Load shares the reset path so it can abort a stalled beat.
            r_state <= i_seed;
            r_tap   <= w_tap_san;
            r_fsm   <= IDLE;
            r_valid <= 1'b0;
`ifdef LFSR_STREAM_PERIOD_EN
            r_seed  <= i_seed;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
            if (!i_rst) begin
                r_period <= '0;
            end
`endif
        end else begin
`ifdef LFSR_STREAM_PERIOD_EN
            r_wrap <= 1'b0;
`endif
            case (r_fsm)
                IDLE: begin
                    if (i_en) begin
                        r_fsm   <= RUN;
                        r_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        r_state <= w_next;
                        if (!i_en) begin
                            r_fsm   <= IDLE;
                            r_valid <= 1'b0;
                        end
`ifdef LFSR_STREAM_PERIOD_EN
                        if (w_next == r_seed) begin
                            r_wrap   <= 1'b1;
                            r_period <= w_cnt_inc;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
`endif
                    end
                end
            endcase
        end
    end

    assign o_out.out_valid = r_valid;
    assign o_out.out_data  = w_fb;
    assign o_state         = r_state;
endmodule

// File: tb/tb_lfsr_stream.sv
// tb/tb_lfsr_stream.sv - directed table-driven bench for lfsr_stream
module tb_lfsr_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tap;
    logic [7:0] seed;
    logic       load;
    logic       en;
    logic       ready;
    logic [7:0] st1;
    logic [7:0] st4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_stream_if #(.STEP(1)) s1_if ();
    lfsr_stream_if #(.STEP(4)) s4_if ();
    assign s1_if.out_ready = ready;
    assign s4_if.out_ready = ready;

`ifdef LFSR_STREAM_PERIOD_EN
    logic       wrap1, wrap4;
    logic [8:0] per1, per4;
`endif

    lfsr_stream #(.WIDTH(8), .STEP(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_tap(tap), .i_seed(seed), .i_load(load), .i_en(en),
        .o_out(s1_if.master),
`ifdef LFSR_STREAM_PERIOD_EN
        .o_wrap(wrap1), .o_period(per1),
`endif
        .o_state(st1)
    );

    lfsr_stream #(.WIDTH(8), .STEP(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_tap(tap), .i_seed(seed), .i_load(load), .i_en(en),
        .o_out(s4_if.master),
`ifdef LFSR_STREAM_PERIOD_EN
        .o_wrap(wrap4), .o_period(per4),
`endif
        .o_state(st4)
    );

`ifdef LFSR_STREAM_PERIOD_EN
    logic [3:0] tap_p, seed_p, st_p;
    logic       load_p, en_p, ready_p, wrap_p;
    logic [4:0] per_p;
    lfsr_stream_if #(.STEP(1)) sp_if ();
    assign sp_if.out_ready = ready_p;

    lfsr_stream #(.WIDTH(4), .STEP(1)) dutp (
        .i_clk(clk), .i_rst(rst), .i_tap(tap_p), .i_seed(seed_p), .i_load(load_p), .i_en(en_p),
        .o_out(sp_if.master), .o_wrap(wrap_p), .o_period(per_p), .o_state(st_p)
    );
`endif

    typedef struct {
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_state;
        logic       exp_data;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'h02, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h04, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h08, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'h10, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'h20, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'h40, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'h80, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'h00, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'h1D, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h1D, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h1D, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 8'h3A, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 8'h74, 1'b0};

        rst = 1'b0; tap = 8'h1D; seed = 8'h01; load = 1'b0; en = 1'b0; ready = 1'b0;
`ifdef LFSR_STREAM_PERIOD_EN
        tap_p = 4'h2; seed_p = 4'h1; load_p = 1'b0; en_p = 1'b0; ready_p = 1'b0;
`endif
        tick();
        chk("reset_state", 32'(st1), 32'h01);
        chk("reset_valid", 32'(s1_if.out_valid), 32'h0);

        rst = 1'b1; en = 1'b1; ready = 1'b1;
        tick();
        chk("run_valid", 32'(s1_if.out_valid), 32'h1);
        chk("run_state0", 32'(st1), 32'h01);
        chk("run_data0", 32'(s1_if.out_data), 32'h0);

        for (int i = 0; i < 13; i++) begin
            ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(s1_if.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_state", i), 32'(st1), 32'(vecs[i].exp_state));
            chk($sformatf("vec%0d_data", i), 32'(s1_if.out_data), 32'(vecs[i].exp_data));
        end

        // Degenerate tap masks fall back to 0x02.
        for (int k = 0; k < 2; k++) begin
            tap = (k == 0) ? 8'hFF : 8'h00; seed = 8'h00; load = 1'b1; en = 1'b1; ready = 1'b1;
            tick();
            chk($sformatf("fb%0d_load_valid", k), 32'(s1_if.out_valid), 32'h0);
            chk($sformatf("fb%0d_load_state", k), 32'(st1), 32'h00);
            load = 1'b0;
            tick();
            chk($sformatf("fb%0d_data", k), 32'(s1_if.out_data), 32'h1);
            tick();
            chk($sformatf("fb%0d_state", k), 32'(st1), 32'h03);
        end

        ready = 1'b0;
        tick();
        chk("stall_hold", 32'(st1), 32'h03);
        seed = 8'hA5; tap = 8'h1D; load = 1'b1;
        tick();
        chk("midload_valid", 32'(s1_if.out_valid), 32'h0);
        chk("midload_state", 32'(st1), 32'hA5);
        load = 1'b0;
        tick();
        chk("reload_valid", 32'(s1_if.out_valid), 32'h1);
        chk("reload_data", 32'(s1_if.out_data), 32'h1);

        en = 1'b0;
        tick();
        chk("en0_stall_valid1", 32'(s1_if.out_valid), 32'h1);
        tick();
        chk("en0_stall_valid2", 32'(s1_if.out_valid), 32'h1);
        chk("en0_stall_state", 32'(st1), 32'hA5);
        ready = 1'b1;
        tick();
        chk("en0_accept_state", 32'(st1), 32'h57);
        chk("en0_accept_valid", 32'(s1_if.out_valid), 32'h0);
        tick();
        chk("idle_hold_state", 32'(st1), 32'h57);

        rst = 1'b0; seed = 8'h80; tap = 8'h1D; ready = 1'b0;
        tick();
        chk("midrst_state", 32'(st1), 32'h80);
        chk("midrst_valid", 32'(s1_if.out_valid), 32'h0);
        rst = 1'b1; en = 1'b1;
        tick();
        chk("step4_valid", 32'(s4_if.out_valid), 32'h1);
        chk("step4_data", 32'(s4_if.out_data), 32'h2);
        ready = 1'b1;
        tick();
        chk("step4_state", 32'(st4), 32'h74);

`ifdef LFSR_STREAM_PERIOD_EN
        load_p = 1'b1;
        tick();
        load_p = 1'b0; en_p = 1'b1; ready_p = 1'b1;
        tick();
        for (int b = 1; b <= 16; b++) begin
            tick();
            if (b < 16) chk($sformatf("per_nowrap%0d", b), 32'(wrap_p), 32'h0);
        end
        chk("per_wrap", 32'(wrap_p), 32'h1);
        chk("per_period", 32'(per_p), 32'd16);
        chk("per_state", 32'(st_p), 32'h1);
        tick();
        chk("per_wrap_pulse", 32'(wrap_p), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("per_rst_wrap", 32'(wrap_p), 32'h0);
        chk("per_rst_period", 32'(per_p), 32'h0);
        rst = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
